// File: rtl/tex_cache_inval_ctrl.sv
// tex_cache_inval_ctrl: N-way tag/valid store for the TMU L1 texture cache,
// with a notify FIFO feeding a one-set-per-cycle range/flush invalidation walker.
module tex_cache_inval_ctrl #(
  parameter int ADDR_W     = 40,
  parameter int LINE_BYTES = 64,
  parameter int NUM_SETS   = 256,
  parameter int NUM_WAYS   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ntf_valid,
  output logic                        ntf_ready,
  input  logic [ADDR_W-1:0]           ntf_addr,
  input  logic [LEN_W-1:0]            ntf_len,
  input  logic [1:0]                  ntf_mode,
  input  logic                        fill_v,
  input  logic [ADDR_W-1:0]           fill_addr,
  input  logic [$clog2(NUM_WAYS)-1:0] fill_way,
  input  logic                        lk_v,
  input  logic [ADDR_W-1:0]           lk_addr,
  output logic                        lk_hit,
  output logic [$clog2(NUM_WAYS)-1:0] lk_way,
  output logic                        inval_pulse,
  output logic [$clog2(NUM_WAYS):0]   inval_cnt,
  output logic                        flush_done,
  output logic                        bad_cmd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int ENT_W  = LINE_W + LEN_W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, FLUSH = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic [LINE_W-1:0]   cur_reg, cur_next;
  logic [LEN_W-1:0]    rem_reg, rem_next;
  logic [IDX_W-1:0]    fset_reg, fset_next;
  logic                pop, bad_cmd_next, flush_last;

  // Notify FIFO storage and bookkeeping
  logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]    count_reg;
  logic                push;
  logic [ENT_W-1:0]    head;
  logic [LINE_W-1:0]   head_line;
  logic [LEN_W-1:0]    head_len;
  logic [1:0]          head_mode;

  // Tag and valid arrays
  logic [TAG_W-1:0]    tag_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];

  logic [LINE_W-1:0]   fill_line, lk_line, fill_off;
  logic [IDX_W-1:0]    fill_set, lk_set, act_set;
  logic [TAG_W-1:0]    fill_tag, lk_tag, cur_tag;
  logic                clr_en, fill_in_walk, fill_valid_bit;
  logic [NUM_WAYS-1:0] lk_match, fill_mask, clr_eff;
  logic [WAY_W-1:0]    lk_enc;
  logic [WAY_W:0]      clr_cnt;

  // Registered outputs
  logic                lk_hit_reg, inval_pulse_reg, flush_done_reg, bad_cmd_reg;
  logic [WAY_W-1:0]    lk_way_reg;
  logic [WAY_W:0]      inval_cnt_reg;

  // Byte-offset bits never participate in tag/set matching
  logic unused_bits;
  assign unused_bits = &{1'b0, ntf_addr[OFF_W-1:0], fill_addr[OFF_W-1:0], lk_addr[OFF_W-1:0]};

  assign ntf_ready  = (count_reg != LVL_W'(FIFO_DEPTH));
  assign push       = ntf_valid && ntf_ready;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);
  assign fifo_level = count_reg;

  assign head      = fifo_mem[rd_ptr_reg];
  assign head_line = head[ENT_W-1 -: LINE_W];
  assign head_len  = head[2 +: LEN_W];
  assign head_mode = head[1:0];

  assign fill_line = fill_addr[ADDR_W-1:OFF_W];
  assign fill_set  = fill_line[IDX_W-1:0];
  assign fill_tag  = fill_line[LINE_W-1:IDX_W];
  assign lk_line   = lk_addr[ADDR_W-1:OFF_W];
  assign lk_set    = lk_line[IDX_W-1:0];
  assign lk_tag    = lk_line[LINE_W-1:IDX_W];
  assign cur_tag   = cur_reg[LINE_W-1:IDX_W];
  assign act_set   = (state_reg == FLUSH) ? fset_reg : cur_reg[IDX_W-1:0];
  assign clr_en    = (state_reg == WALK) || (state_reg == FLUSH);

  // A fill landing inside the not-yet-walked part of the range (modular distance
  // from cur no larger than rem) would be stale, so it is installed invalid.
  assign fill_off       = fill_line - cur_reg;
  assign fill_in_walk   = (fill_off <= LINE_W'(rem_reg));
  assign fill_valid_bit = !(((state_reg == WALK) && fill_in_walk) || (state_reg == FLUSH));

  // Per-way probe match, fill target decode and clear decision (fill beats clear)
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    assign lk_match[gi]  = valid_mem[lk_set][gi] && (tag_mem[lk_set][gi] == lk_tag);
    assign fill_mask[gi] = fill_v && (fill_set == act_set) && (fill_way == WAY_W'(gi));
    assign clr_eff[gi]   = clr_en && !fill_mask[gi] && valid_mem[act_set][gi] &&
                           ((state_reg == FLUSH) || (tag_mem[act_set][gi] == cur_tag));
  end

  // Lowest-numbered matching way wins the probe
  always_comb begin
    lk_enc = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (lk_match[w]) lk_enc = WAY_W'(w);
    end
  end

  // Number of ways cleared this cycle
  always_comb begin
    clr_cnt = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      clr_cnt = clr_cnt + (WAY_W + 1)'(clr_eff[w]);
    end
  end

  // FIFO entry write (payload needs no reset; occupancy is tracked separately)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {ntf_addr[ADDR_W-1:OFF_W], ntf_len, ntf_mode};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Walker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cur_reg   <= '0;
      rem_reg   <= '0;
      fset_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      rem_reg   <= rem_next;
      fset_reg  <= fset_next;
    end
  end

  // Walker next-state: pop in IDLE, one line per WALK cycle, one set per FLUSH cycle
  always_comb begin
    state_next   = state_reg;
    cur_next     = cur_reg;
    rem_next     = rem_reg;
    fset_next    = fset_reg;
    pop          = 1'b0;
    bad_cmd_next = 1'b0;
    flush_last   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop = 1'b1;
          case (head_mode)
            2'b00: begin
              cur_next   = head_line;
              rem_next   = head_len;
              state_next = WALK;
            end
            2'b01: begin
              fset_next  = '0;
              state_next = FLUSH;
            end
            default: bad_cmd_next = 1'b1;
          endcase
        end
      end
      WALK: begin
        if (rem_reg == '0) begin
          state_next = IDLE;
        end else begin
          cur_next = cur_reg + 1'b1;
          rem_next = rem_reg - 1'b1;
        end
      end
      FLUSH: begin
        if (fset_reg == IDX_W'(NUM_SETS - 1)) begin
          flush_last = 1'b1;
          state_next = IDLE;
        end else begin
          fset_next = fset_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Valid array: clear walked/flushed ways, then apply the fill on top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) valid_mem[s] <= '0;
    end else begin
      if (clr_en) valid_mem[act_set] <= valid_mem[act_set] & ~clr_eff;
      if (fill_v) valid_mem[fill_set][fill_way] <= fill_valid_bit;
    end
  end

  // Tag array written only by fills
  always_ff @(posedge clk) begin
    if (fill_v) tag_mem[fill_set][fill_way] <= fill_tag;
  end

  // Registered probe result and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_hit_reg      <= 1'b0;
      lk_way_reg      <= '0;
      inval_pulse_reg <= 1'b0;
      inval_cnt_reg   <= '0;
      flush_done_reg  <= 1'b0;
      bad_cmd_reg     <= 1'b0;
    end else begin
      lk_hit_reg      <= lk_v && (lk_match != '0);
      lk_way_reg      <= (lk_v && (lk_match != '0)) ? lk_enc : '0;
      inval_pulse_reg <= (clr_eff != '0);
      inval_cnt_reg   <= clr_cnt;
      flush_done_reg  <= flush_last;
      bad_cmd_reg     <= bad_cmd_next;
    end
  end

  assign lk_hit      = lk_hit_reg;
  assign lk_way      = lk_way_reg;
  assign inval_pulse = inval_pulse_reg;
  assign inval_cnt   = inval_cnt_reg;
  assign flush_done  = flush_done_reg;
  assign bad_cmd     = bad_cmd_reg;

endmodule
